// File: rtl/imem_prog.sv
// Field-loadable instruction memory: hardware clear after reset, valid/ready program load, fetch port.
// Define IMEM_REGISTERED_READ_EN to register instruction/instr_valid (1-cycle fetch latency).
module imem_prog #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2048,
  parameter int               ADR_W     = 11,
  parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADR_W-1:0] read_adr,
  output logic [WIDTH-1:0] instruction,
  output logic             instr_valid,
  input  logic             ld_start,
  input  logic [ADR_W-1:0] ld_base,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  output logic [ADR_W:0]   ld_count,
  output logic             ld_ovf,
  output logic             mem_rdy
);

  localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADR_W-1:0] LAST_ADR  = ADR_W'(DEPTH - 1);
  localparam logic [ADR_W:0]   DEPTH_CNT = (ADR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_t;

  state_t           state_reg;
  logic [ADR_W-1:0] clr_cnt_reg;
  logic [ADR_W-1:0] ptr_reg;
  logic [ADR_W:0]   ld_count_reg;
  logic             ld_ovf_reg;
  logic             mem_rdy_reg;
  logic             ld_ready_reg;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_en;
  logic [ADR_W-1:0] wr_adr;
  logic [WIDTH-1:0] wr_data;

  // Single write port shared by the clear sweep and the load stream.
  always_comb begin
    wr_en   = 1'b0;
    wr_adr  = clr_cnt_reg;
    wr_data = '0;
    if (rst) begin
      if (state_reg == CLEAR) begin
        wr_en = 1'b1;
      end else if (state_reg == LOAD && ld_valid) begin
        wr_en   = 1'b1;
        wr_adr  = ptr_reg;
        wr_data = ld_data;
      end
    end
    if ({1'b0, wr_adr} >= DEPTH_CNT) wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_adr[IDX_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= CLEAR;
      clr_cnt_reg  <= '0;
      ptr_reg      <= '0;
      ld_count_reg <= '0;
      ld_ovf_reg   <= 1'b0;
      mem_rdy_reg  <= 1'b0;
      ld_ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == LAST_ADR) begin
            clr_cnt_reg <= '0;
            state_reg   <= IDLE;
            mem_rdy_reg <= 1'b1;
          end
        end
        IDLE: begin
          if (ld_start) begin
            ptr_reg      <= ld_base;
            ld_count_reg <= '0;
            ld_ovf_reg   <= 1'b0;
            state_reg    <= LOAD;
            mem_rdy_reg  <= 1'b0;
            ld_ready_reg <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_valid) begin
            ptr_reg <= (ptr_reg == LAST_ADR) ? '0 : ptr_reg + 1'b1;
            // Count saturates at DEPTH; any further word flags overflow but is still written.
            if (ld_count_reg == DEPTH_CNT) ld_ovf_reg <= 1'b1;
            else                           ld_count_reg <= ld_count_reg + 1'b1;
            if (ld_last) begin
              state_reg    <= IDLE;
              mem_rdy_reg  <= 1'b1;
              ld_ready_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg    <= CLEAR;
          clr_cnt_reg  <= '0;
          mem_rdy_reg  <= 1'b0;
          ld_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ld_count = ld_count_reg;
  assign ld_ovf   = ld_ovf_reg;
  assign mem_rdy  = mem_rdy_reg;
  assign ld_ready = ld_ready_reg;

  logic             fetch_valid;
  logic [WIDTH-1:0] fetch_word;

  always_comb begin
    fetch_valid = rst && (state_reg == IDLE) && ({1'b0, read_adr} < DEPTH_CNT);
    fetch_word  = NOP_INSTR;
    if (fetch_valid) fetch_word = mem[read_adr[IDX_W-1:0]];
  end

`ifdef IMEM_REGISTERED_READ_EN
  logic [WIDTH-1:0] instruction_reg;
  logic             instr_valid_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      instruction_reg <= NOP_INSTR;
      instr_valid_reg <= 1'b0;
    end else begin
      instruction_reg <= fetch_word;
      instr_valid_reg <= fetch_valid;
    end
  end

  assign instruction = instruction_reg;
  assign instr_valid = instr_valid_reg;
`else
  assign instruction = fetch_word;
  assign instr_valid = fetch_valid;
`endif

endmodule

// File: doc/imem_prog.md
# imem_prog

Parametrised, field-loadable instruction memory for the single-cycle core. It clears the whole array in hardware after reset, one word per cycle. It accepts a program stream over a valid/ready load port and serves instruction fetches only once the array is stable. It sits between the program loader (UART/testbench) and the fetch stage, replacing the fixed, reset-cleared instruction ROM.

## Interface
- WIDTH, 32, instruction word width in bits
- DEPTH, 2048, number of words; must satisfy DEPTH ≤ 2^ADR_W
- ADR_W, 11, word-address width of read and load ports
- NOP_INSTR, 32'h0000_0013, word driven on `instruction` when fetch is not valid
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-low
- read_adr  in  ADR_W  fetch word address
- instruction  out  WIDTH  fetched word
- instr_valid  out  1  high when `instruction` is a real memory word
- ld_start  in  1  one-cycle pulse that opens a load session (sampled only in IDLE)
- ld_base  in  ADR_W  first write address of the session, sampled with ld_start
- ld_valid  in  1  ld_data/ld_last valid
- ld_ready  out  1  block accepts a word this cycle
- ld_data  in  WIDTH  word to write
- ld_last  in  1  marks final word of session
- ld_count  out  ADR_W+1  words accepted in current/last session
- ld_ovf  out  1  sticky: session wrote more than DEPTH words
- mem_rdy  out  1  high in IDLE

## Operation
- States: CLEAR, IDLE, LOAD.
- rst low: state=CLEAR, clear counter=0, ld_count=0, ld_ovf=0, no array writes. Outputs: ld_ready=0, mem_rdy=0, instr_valid=0, instruction=NOP_INSTR.
- CLEAR: each cycle writes 0 to mem[cnt], then cnt++. After writing DEPTH-1, go to IDLE. Inputs on the load port are ignored.
- IDLE: mem_rdy=1, ld_ready=0. On ld_start=1: ptr<=ld_base, ld_count<=0, ld_ovf<=0, go to LOAD.
- LOAD: ld_ready=1. A word transfers on ld_valid&&ld_ready: mem[ptr]<=ld_data, ld_count++.
  - ptr++ wraps from DEPTH-1 to 0.
  - When ld_count is already DEPTH on a transfer, set ld_ovf. ld_count saturates at DEPTH; the write still occurs.
  - A transfer with ld_last=1 returns to IDLE on the same edge.
- ld_start is ignored in CLEAR and LOAD. ld_valid in IDLE is ignored, since ld_ready=0.
- Fetch: in IDLE, instruction=mem[read_adr], instr_valid=1. In CLEAR/LOAD, instruction=NOP_INSTR, instr_valid=0.
- read_adr ≥ DEPTH (when DEPTH<2^ADR_W): instruction=NOP_INSTR, instr_valid=0 in any state.
- Reset mid-session: the session is aborted, the FSM returns to CLEAR, and the full array is re-cleared.

## Timing
- Clear duration: edge k after rst rises (k=1..DEPTH) writes address k-1. State is IDLE after edge DEPTH; mem_rdy is first high in the following cycle.
- Load throughput: one word per cycle while ld_valid stays high. Entry to LOAD takes one cycle after ld_start.
- A word written on edge n is fetchable from the cycle after the return to IDLE.
- ld_count and ld_ovf update on the transfer edge.
- Fetch latency: combinational, 0 cycles (see Configuration).

## Configuration
- IMEM_REGISTERED_READ_EN defined:
  - instruction and instr_valid are registered.
  - The value present in the cycle after edge n is what the combinational rule gives for the state and read_adr sampled at edge n. Latency is 1 cycle.
  - Reset values are NOP_INSTR and 0.
  - The first valid fetch appears one cycle after mem_rdy rises.
- IMEM_REGISTERED_READ_EN undefined: purely combinational fetch path as in Operation.

## Test plan
- Reset release, DEPTH=16 -> mem_rdy low for cycles 1..16, high from cycle 17. All reads return 0 with instr_valid=1.
- ld_start, ld_base=4, words A0..A3 with ld_last on A3 -> mem[4..7]=A0..A3, ld_count=4, ld_ovf=0. Back in IDLE, read_adr=5 gives A1.
- ld_valid toggled 1,0,1,0 during LOAD -> only cycles with ld_valid=1 write; ld_ready stays 1; ld_count matches transfers.
- ld_base=14, DEPTH=16, 19 words -> ptr wraps 15→0, mem[0] holds word 19's data, ld_ovf=1, ld_count=16.
- rst pulled low after 2 words of a session -> FSM goes to CLEAR, mem_rdy=0, then full re-clear leaves mem[base..base+1]=0.
- With IMEM_REGISTERED_READ_EN, read_adr changes 3→9 at edge n -> instruction shows mem[9] one cycle later, and NOP_INSTR with instr_valid=0 during LOAD.
